context_switch_ctrl: RTL
========================

Name: context_switch_ctrl

Overview:
- Context-switch sequencer that sits directly upstream of ram_data and generates its control strobes: changeProgram, spc/enderecoSpc, nextProgram, lpc and endProgram.
- Switches the core between the OS (program slot 1) and one user program. Triggers are an OS launch request, quantum expiry or a user halt.
- Freezes the pipeline during a switch, then reloads the PC from the value ram_data returns.

Parameters:
DATA_WIDTH  32  width of PC, program id and RAM data
QUANTUM  64  user instructions retired before preemption (>=2)
CNT_WIDTH  16  width of the quantum counter

Ports:
clock  in  1  system clock; ram_data read_clock and write_clock are driven from it
reset  in  1  synchronous, active-high
instr_retire  in  1  one pulse per retired instruction
halt_req  in  1  user program executed halt (level, sampled in USER_RUN)
sched_req  in  1  OS requests launch/resume of a user program (sampled in OS_RUN)
sched_prog  in  DATA_WIDTH  program id to launch (>=2)
pc_current  in  DATA_WIDTH  absolute PC of the running program
ram_q  in  DATA_WIDTH  ram_data q
change_program  out  1  to ram_data changeProgram
sched_addr  out  DATA_WIDTH  muxed onto endereco_leitura while change_program=1; equals sched_prog-1
spc  out  1  save-PC strobe
endereco_spc  out  DATA_WIDTH  PC to save (pc_current, registered in SAVE)
next_program  out  1  ram_data nextProgram
lpc  out  1  load-PC strobe
end_program  out  1  ram_data endProgram
pc_load  out  1  load PC register this cycle
pc_load_value  out  DATA_WIDTH  restored PC
stall  out  1  freeze fetch/execute
in_user  out  1  user program currently active

Behaviour:
- Reset: state OS_RUN; every output 0; quantum counter 0; in_user 0. Reset in any state aborts the sequence immediately. No strobe is asserted in the cycle after reset.
- Every output is a registered Moore decode of state; stall=1 in every state except OS_RUN and USER_RUN.
- OS_RUN:
  - sched_req=1 -> SAVE, with change_program=1 for exactly that SAVE cycle.
  - sched_addr is held at sched_prog-1 in that cycle.
- USER_RUN:
  - instr_retire increments the counter.
  - Preemption: retire when counter==QUANTUM-1 -> SAVE, counter cleared.
  - halt_req=1 -> END. halt wins over a simultaneous expiry.
- SAVE (1 cycle): spc=1, endereco_spc=pc_current sampled on SAVE entry -> SWITCH.
- SWITCH (1 cycle): next_program=1 -> LOAD. The ram slot change is visible from the next cycle.
- LOAD (1 cycle): lpc=1 -> APPLY. ram_q is valid in APPLY (1-cycle read latency).
- APPLY (1 cycle): pc_load=1, pc_load_value=ram_q.
  - Next state is USER_RUN if in_user was 0, else OS_RUN.
  - in_user toggles at APPLY exit.
- END (1 cycle): end_program=1 -> END_W1.
- END_W1 and END_W2 (1 cycle each): no strobes. These cover ram_data's bookkeeping and slot-reset cycles, during which spc, we and next_program must stay 0.
- END_W2 -> SWITCH. The halted PC is not saved; the OS PC is restored via LOAD/APPLY.
- Counter width rule: counter saturates at 2^CNT_WIDTH-1. It resets on every APPLY.
- instr_retire is ignored while stall=1.
- sched_req is ignored outside OS_RUN.
- halt_req is ignored outside USER_RUN.
- Full switch latency: OS->user or user->OS is 4 stall cycles (SAVE, SWITCH, LOAD, APPLY). Halt->OS is 6 (END, W1, W2, SWITCH, LOAD, APPLY).
- Never assert two of spc, next_program, lpc, end_program in the same cycle.

Optional Feature:
- Macro CTX_PREEMPT_EN.
- Defined: quantum preemption as above.
- Undefined: counter logic is removed. USER_RUN leaves only on halt_req, giving cooperative scheduling; QUANTUM is unused and all other timing is identical.

Test Plan:
- Reset: hold reset 3 cycles mid-LOAD -> all outputs 0, state OS_RUN, no strobes the following cycle.
- Launch: OS_RUN, sched_req=1 with sched_prog=2, pc_current=0x10 -> next cycle change_program=1, sched_addr=1, spc=1, endereco_spc=0x10. Then next_program, then lpc. With ram_q=0 in APPLY: pc_load=1, pc_load_value=0, in_user=1. stall high exactly 4 cycles.
- Preempt (CTX_PREEMPT_EN, QUANTUM=4): 4 retires in USER_RUN with pc_current=0x20 -> spc with endereco_spc=0x20. OS PC from ram_q=0x14 is loaded; in_user=0.
- Halt: USER_RUN, halt_req=1 -> end_program pulses once, 2 idle cycles, next_program, lpc, pc_load with ram_q. spc never asserted; stall 6 cycles.
- Simultaneous: halt_req on the same cycle as the 4th retire (QUANTUM=4) -> END path taken, spc never asserted.
- Cooperative build (CTX_PREEMPT_EN undefined): 1000 retires in USER_RUN -> no switch. Only halt_req returns control to the OS.

Source files
------------

// File: rtl/context_switch_ctrl.sv
// Context-switch sequencer driving the ram_data program-slot strobes (OS <-> one user program).
// Define CTX_PREEMPT_EN for quantum preemption; without it user programs run until they halt.
module context_switch_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int QUANTUM    = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_retire,
  input  logic                  halt_req,
  input  logic                  sched_req,
  input  logic [DATA_WIDTH-1:0] sched_prog,
  input  logic [DATA_WIDTH-1:0] pc_current,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  change_program,
  output logic [DATA_WIDTH-1:0] sched_addr,
  output logic                  spc,
  output logic [DATA_WIDTH-1:0] endereco_spc,
  output logic                  next_program,
  output logic                  lpc,
  output logic                  end_program,
  output logic                  pc_load,
  output logic [DATA_WIDTH-1:0] pc_load_value,
  output logic                  stall,
  output logic                  in_user
);

  typedef enum logic [3:0] {
    S_OS_RUN   = 4'd0,
    S_USER_RUN = 4'd1,
    S_SAVE     = 4'd2,
    S_SWITCH   = 4'd3,
    S_LOAD     = 4'd4,
    S_APPLY    = 4'd5,
    S_END      = 4'd6,
    S_END_W1   = 4'd7,
    S_END_W2   = 4'd8
  } state_t;

  state_t                state_q;
  state_t                state_next;
  logic                  in_user_q;
  logic [DATA_WIDTH-1:0] saved_pc_q;
  logic [DATA_WIDTH-1:0] sched_addr_q;
  logic                  quantum_expired;

  if (QUANTUM < 2 || CNT_WIDTH < 1) begin : g_param_check
    $error("context_switch_ctrl: QUANTUM must be >= 2 and CNT_WIDTH >= 1");
  end

`ifdef CTX_PREEMPT_EN
  localparam logic [CNT_WIDTH-1:0] QUANTUM_LAST = CNT_WIDTH'(QUANTUM - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] cnt_q;

  assign quantum_expired = instr_retire && (cnt_q == QUANTUM_LAST);

  // Retires only count while the user program is actually running; halt takes priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == S_APPLY) begin
      cnt_q <= '0;
    end else if (state_q == S_USER_RUN && instr_retire && !halt_req) begin
      if (cnt_q == QUANTUM_LAST) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_retire;

  assign unused_retire   = instr_retire;
  assign quantum_expired = 1'b0;
`endif

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_OS_RUN:   if (sched_req) state_next = S_SAVE;
      S_USER_RUN: begin
        if (halt_req) begin
          state_next = S_END;
        end else if (quantum_expired) begin
          state_next = S_SAVE;
        end
      end
      S_SAVE:     state_next = S_SWITCH;
      S_SWITCH:   state_next = S_LOAD;
      S_LOAD:     state_next = S_APPLY;
      S_APPLY:    state_next = in_user_q ? S_OS_RUN : S_USER_RUN;
      S_END:      state_next = S_END_W1;
      S_END_W1:   state_next = S_END_W2;
      S_END_W2:   state_next = S_SWITCH;
      default:    state_next = S_OS_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_OS_RUN;
      in_user_q    <= 1'b0;
      saved_pc_q   <= '0;
      sched_addr_q <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == S_APPLY) begin
        in_user_q <= ~in_user_q;
      end
      if (state_next == S_SAVE) begin
        saved_pc_q <= pc_current;
      end
      // ram_data slots are 0-based for the read port, program ids are 1-based.
      if (state_q == S_OS_RUN && sched_req) begin
        sched_addr_q <= sched_prog - 1'b1;
      end
    end
  end

  // Moore decode of the state register; a SAVE reached from the OS side is a launch.
  always_comb begin
    change_program = 1'b0;
    sched_addr     = '0;
    spc            = 1'b0;
    endereco_spc   = '0;
    next_program   = 1'b0;
    lpc            = 1'b0;
    end_program    = 1'b0;
    pc_load        = 1'b0;
    pc_load_value  = '0;
    stall          = 1'b1;
    in_user        = in_user_q;
    case (state_q)
      S_OS_RUN, S_USER_RUN: stall = 1'b0;
      S_SAVE: begin
        spc          = 1'b1;
        endereco_spc = saved_pc_q;
        if (!in_user_q) begin
          change_program = 1'b1;
          sched_addr     = sched_addr_q;
        end
      end
      S_SWITCH: next_program = 1'b1;
      S_LOAD:   lpc          = 1'b1;
      S_APPLY: begin
        pc_load       = 1'b1;
        pc_load_value = ram_q;
      end
      S_END:    end_program = 1'b1;
      default:  ;
    endcase
  end

endmodule
